// File: rtl/rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared definitions for the N-channel arbitrating multiplexer:
//   MODE_RR     - round-robin arbitration (rotating priority pointer)
//   MODE_FIXED  - fixed priority, lowest channel index wins
//   idx_width() - width of a channel index, never narrower than one bit
// -----------------------------------------------------------------------------
package rr_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // A two-channel mux still needs one index bit, so clamp at 1.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Purely combinational rotating-priority arbiter. Starting at channel ptr and
// walking upward (wrapping from CHANNELS-1 to 0), the first requesting channel
// receives the grant. With ptr tied to zero this degenerates into a fixed
// lowest-index-wins arbiter.
// Ports:
//   req        in  CHANNELS  request vector (one bit per channel)
//   ptr        in  IW        channel with highest priority this cycle
//   grant      out CHANNELS  one-hot grant, all zero when nothing requests
//   grant_idx  out IW        binary index of the granted channel (0 if none)
//   grant_any  out 1         at least one channel is granted
// -----------------------------------------------------------------------------
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SW = IW + 1;

  logic [SW-1:0] cand_s;
  logic [IW-1:0] cand_idx_s;
  logic          found_s;

  // Rotating search: the first requester at or above ptr (modulo CHANNELS) wins.
  always_comb begin
    grant      = {CHANNELS{1'b0}};
    grant_idx  = {IW{1'b0}};
    found_s    = 1'b0;
    cand_s     = {SW{1'b0}};
    cand_idx_s = {IW{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      cand_s = {1'b0, ptr} + SW'(k);
      if (cand_s >= SW'(CHANNELS)) begin
        cand_s = cand_s - SW'(CHANNELS);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[IW-1:0];
      if (!found_s && req[cand_idx_s]) begin
        found_s           = 1'b1;
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_any = found_s;

endmodule : rr_grant

// File: rtl/rr_mux_n.sv
// -----------------------------------------------------------------------------
// rr_mux_n
// N-channel valid/ready multiplexer with a one-word registered output stage.
// Each cycle the arbiter (round-robin or fixed priority, chosen by MODE)
// grants one valid channel; the word is accepted whenever the output register
// is empty or is being drained in the same cycle, giving one-cycle latency and
// full throughput while out_ready stays high.
// Parameters:
//   WIDTH     data bits per channel (>= 1)
//   CHANNELS  number of input channels (2..16)
//   MODE      MODE_RR (0) round-robin, MODE_FIXED (1) lowest index wins
// Ports:
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous active-high reset
//   in_data    in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        channel i offers a word
//   in_ready   out  CHANNELS        channel i word accepted this cycle
//   out_data   out  WIDTH           registered selected word
//   out_valid  out  1               out_data/out_chan hold a word
//   out_ready  in   1               downstream accepts the word this cycle
//   out_chan   out  idx_width       source channel of out_data
// -----------------------------------------------------------------------------
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*WIDTH-1:0]      in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [idx_width(CHANNELS)-1:0] out_chan
);

  localparam int            IW       = idx_width(CHANNELS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

  // State: priority pointer and the output register.
  logic [IW-1:0]    ptr_q,       ptr_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [IW-1:0]    out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;

  logic [IW-1:0]       ptr_sel_s;
  logic [CHANNELS-1:0] grant_s;
  logic [IW-1:0]       grant_idx_s;
  logic                grant_any_s;
  logic                load_en_s;
  logic                in_xfer_s;
  logic [WIDTH-1:0]    sel_data_s;

  // Fixed-priority mode searches from channel 0 every cycle.
  always_comb begin
    if (MODE == MODE_FIXED) begin
      ptr_sel_s = {IW{1'b0}};
    end else begin
      ptr_sel_s = ptr_q;
    end
  end

  rr_grant #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_grant (
    .req       (in_valid),
    .ptr       (ptr_sel_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // The output register can take a new word when empty or draining this cycle.
  // Reset is folded in so in_ready drops immediately, not at the next edge.
  always_comb begin
    load_en_s = (!out_valid_q || out_ready) && !reset;
    in_xfer_s = grant_any_s && load_en_s;
    in_ready  = grant_s & {CHANNELS{load_en_s}};
  end

  // AND-OR data select driven by the one-hot grant.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // Next-state for the output register and pointer.
  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (in_xfer_s) begin
      out_data_d  = sel_data_s;
      out_chan_d  = grant_idx_s;
      out_valid_d = 1'b1;
      if (MODE == MODE_FIXED) begin
        ptr_d = {IW{1'b0}};
      end else if (grant_idx_s == LAST_IDX) begin
        ptr_d = {IW{1'b0}};
      end else begin
        ptr_d = grant_idx_s + IW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it: data/chan keep their last value.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any held word and restarts the search at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= {IW{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_chan_q  <= {IW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule : rr_mux_n
